ahb_sram_ctrl: RTL and testbench
================================

# ahb_sram_ctrl

Parametrised single-port AHB-Lite SRAM slave with an integrated March C- BIST engine. It generalises the fixed 8k×8 banked SRAM subsystem along four axes: configurable data width and depth, programmable read wait states, hazard-free read-after-write forwarding, and address/size error responses. It sits directly on the AHB bus, one instance per memory region, and contains its own behavioural storage array.

## Interface
- DATA_W, 32, bus and word width in bits; one of 32 or 64.
- MEM_BYTES, 32768, capacity in bytes; power of two, ≥ 4·(DATA_W/8).
- WAIT_STATES, 0, extra data-phase cycles inserted on reads only; range 0..3.
- N (derived), MEM_BYTES/(DATA_W/8), word count.

- hclk  in  1  sole clock, rising edge.
- hreset  in  1  synchronous, active-high reset.
- hsel  in  1  slave select.
- haddr  in  32  byte address.
- hwrite  in  1  1 = write.
- hsize  in  3  0 byte, 1 half, 2 word, 3 dword (DATA_W=64 only).
- htrans  in  2  IDLE/BUSY/NONSEQ/SEQ; only htrans[1] is significant.
- hready  in  1  bus ready.
- hwdata  in  DATA_W  write data, data phase.
- hrdata  out  DATA_W  read data.
- hready_resp  out  1  slave ready.
- hresp  out  2  00 OKAY, 01 ERROR.
- bist_start  in  1  single-cycle start pulse.
- bist_inject  in  1  fault injection; while high, BIST writes to word 3 have bit 0 inverted.
- bist_busy  out  1  BIST owns the array.
- bist_done  out  1  sticky; set when BIST completes.
- bist_fail  out  1  sticky; set on any miscompare.
- bist_fail_addr  out  log2(N)  word index of the first miscompare.

## Operation
- Accept a transfer when hsel & hready & htrans[1] & hready_resp. Register address, size, and direction.
- Error check at address phase:
  - haddr ≥ MEM_BYTES, or
  - hsize > log2(DATA_W/8), or
  - haddr not aligned to 2^hsize, or
  - bist_busy.
- An erroring transfer gets a two-cycle response: cycle 1 hready_resp=0, hresp=01; cycle 2 hready_resp=1, hresp=01. No array access occurs.
- Byte lanes are little-endian. Lane i = bits [8i+7:8i], selected by haddr[log2(DATA_W/8)-1:0] and hsize. A write updates only the enabled lanes.
- Read: array read is issued at the address-phase clock edge using the live haddr; the array is synchronous. Data is held in an output register until the data phase ends.
- Write: hwdata is written on the final data-phase edge.
- Read-after-write hazard: when a read address phase coincides with a write data phase to the same word, hrdata returns the merged new bytes (forwarding), never stale data.
- BIST FSM: IDLE → W0 → R0W1_UP → R1W0_UP → R0W1_DN → R1W0_DN → R0_FIN → IDLE.
  - bist_start is honoured only in IDLE, with no AHB data phase pending. Otherwise it is ignored.
  - W0 writes all-zeros to words 0..N-1, one word per cycle.
  - The four R/W elements take 2 cycles per word: read, then compare-and-write. UP elements run 0→N-1; DN elements run N-1→0.
  - R0_FIN reads words 0..N-1 one per cycle, with pipelined compare, plus 1 drain cycle.
  - On start, bist_done and bist_fail clear. bist_fail_addr is captured on the first miscompare only.

## Timing
- Reset values:
  - hrdata=0, hready_resp=1, hresp=00
  - bist_busy=0, bist_done=0, bist_fail=0, bist_fail_addr=0
  - FSM IDLE, no pending phase
  - Array contents unchanged and undefined
- Write data phase: 1 cycle, hready_resp=1.
- Read data phase: 1+WAIT_STATES cycles. hready_resp=0 for the first WAIT_STATES cycles and 1 in the last. hrdata is valid in the last cycle and stable throughout.
- Back-to-back transfers run at full rate when WAIT_STATES=0.
- A new address phase presented while hready_resp=0 is not sampled.
- BIST run length:
  - bist_busy rises the cycle after bist_start and stays high exactly 10N+1 cycles.
  - bist_done rises on the cycle bist_busy falls.
- hreset mid-transfer or mid-BIST aborts immediately to the reset state. No partial write completes after reset is asserted.

## Test plan
- DATA_W=32, WAIT_STATES=0: write 0xDEADBEEF to 0x10, then read 0x10 back-to-back → hrdata=0xDEADBEEF in the cycle after the read address phase (forwarded), hresp=00.
- Byte write 0xAA to 0x11 over 0x11223344 at 0x10, then word read → 0x1122AA44. Half read at 0x12 → upper lanes 0x1122.
- WAIT_STATES=2: single read → hready_resp goes 0,0,1 and hrdata is valid only in the third cycle. A second address phase is held off until then.
- Read at haddr=MEM_BYTES, then a half write at 0x01 → each gets a two-cycle ERROR (0/01 then 1/01). The array is unchanged at word 0.
- MEM_BYTES=64, DATA_W=32 (N=16): bist_start → busy for 161 cycles, done=1, fail=0. AHB read during busy → ERROR.
- Same BIST run with bist_inject=1 → fail=1, fail_addr=3. hreset asserted mid-run → all BIST outputs return to 0 the next cycle.

Source files
------------

// File: rtl/ahb_sram_ctrl_if.sv
// AHB-Lite slave-side bus bundle for ahb_sram_ctrl.
// hready is the bus-wide ready; hready_resp is this slave's own ready output.
interface ahb_sram_ctrl_if #(
   parameter int unsigned DATA_W = 32
);
   logic              hsel;
   logic [31:0]       haddr;
   logic              hwrite;
   logic [2:0]        hsize;
   logic [1:0]        htrans;
   logic              hready;
   logic [DATA_W-1:0] hwdata;
   logic [DATA_W-1:0] hrdata;
   logic              hready_resp;
   logic [1:0]        hresp;

   modport master (
      output hsel, haddr, hwrite, hsize, htrans, hready, hwdata,
      input  hrdata, hready_resp, hresp
   );

   modport slave (
      input  hsel, haddr, hwrite, hsize, htrans, hready, hwdata,
      output hrdata, hready_resp, hresp
   );
endinterface

// File: rtl/ahb_sram_ctrl.sv
// AHB-Lite SRAM slave with read wait states, write-to-read forwarding, error responses
// and a March C- BIST engine that takes over the array while running.
module ahb_sram_ctrl #(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned MEM_BYTES   = 32768,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic                                      hclk_i,
   input  logic                                      hreset_i,
   ahb_sram_ctrl_if.slave                            ahb_io,
   input  logic                                      bist_start_i,
   input  logic                                      bist_inject_i,
   output logic                                      bist_busy_o,
   output logic                                      bist_done_o,
   output logic                                      bist_fail_o,
   output logic [$clog2(MEM_BYTES/(DATA_W/8))-1:0]   bist_fail_addr_o
);

   localparam int unsigned Lanes = DATA_W / 8;
   localparam int unsigned OffW  = $clog2(Lanes);
   localparam int unsigned N     = MEM_BYTES / Lanes;
   localparam int unsigned AddrW = $clog2(N);
   localparam logic [AddrW-1:0] IdxLast = AddrW'(N - 1);

   typedef enum logic [2:0] {PhIdle, PhRead, PhWrite, PhErr1, PhErr2} ph_e;
   typedef enum logic [2:0] {
      StIdle, StW0, StR0W1Up, StR1W0Up, StR0W1Dn, StR1W0Dn, StR0Fin
   } bist_st_e;

   ph_e                ph_q, ph_d;
   logic [1:0]         wait_q, wait_d;
   logic [AddrW-1:0]   dp_idx_q, dp_idx_d;
   logic [Lanes-1:0]   dp_be_q, dp_be_d;
   logic [DATA_W-1:0]  hrdata_q;
   logic               hready_resp;
   logic [1:0]         hresp;

   bist_st_e           st_q, st_d;
   logic [AddrW-1:0]   idx_q, idx_d, fin_idx_q, fin_idx_d, fail_addr_q, fail_addr_d, cmp_idx;
   logic               sub_q, sub_d, fin_cmp_q, fin_cmp_d;
   logic               done_q, done_d, fail_q, fail_d;
   logic [DATA_W-1:0]  bist_rd_q, bist_wdata, cmp_exp;
   logic               bist_we, cmp_en, miscmp, bist_busy, start_ok;

   logic               accept, ap_err;
   logic [AddrW-1:0]   ap_idx, rd_idx, wr_idx;
   logic [OffW-1:0]    ap_off;
   logic [31:0]        ap_lo, ap_hi, align_mask;
   logic [Lanes-1:0]   ap_be, wr_be;
   logic [DATA_W-1:0]  mem_q [N];
   logic [DATA_W-1:0]  rd_data, fwd_data, wr_data;
   logic               mem_we, ahb_we;
   logic               unused_htrans;

   assign unused_htrans = ahb_io.htrans[0];

   // ---------------- address phase decode ----------------
   assign accept     = ahb_io.hsel & ahb_io.hready & ahb_io.htrans[1] & hready_resp;
   assign ap_idx     = ahb_io.haddr[OffW +: AddrW];
   assign ap_off     = ahb_io.haddr[OffW-1:0];
   assign align_mask = (32'd1 << ahb_io.hsize) - 32'd1;
   assign ap_err     = (ahb_io.haddr >= 32'(MEM_BYTES)) | (ahb_io.hsize > 3'(OffW))
                     | (|(ahb_io.haddr & align_mask)) | bist_busy;

   always_comb begin
      ap_lo = 32'(ap_off);
      ap_hi = ap_lo + (32'd1 << ahb_io.hsize);
      ap_be = '0;
      for (int unsigned i = 0; i < Lanes; i++) begin
         ap_be[i] = (i >= ap_lo) && (i < ap_hi);
      end
   end

   // ---------------- AHB data phase FSM ----------------
   always_ff @(posedge hclk_i) begin
      if (hreset_i) begin
         ph_q     <= PhIdle;
         wait_q   <= '0;
         dp_idx_q <= '0;
         dp_be_q  <= '0;
      end else begin
         ph_q     <= ph_d;
         wait_q   <= wait_d;
         dp_idx_q <= dp_idx_d;
         dp_be_q  <= dp_be_d;
      end
   end

   always_comb begin
      ph_d     = ph_q;
      wait_d   = wait_q;
      dp_idx_d = dp_idx_q;
      dp_be_d  = dp_be_q;
      if (ph_q == PhRead && wait_q != 2'd0) wait_d = wait_q - 2'd1;
      if (accept) begin
         dp_idx_d = ap_idx;
         dp_be_d  = ap_be;
         if (ap_err) begin
            ph_d = PhErr1;
         end else if (ahb_io.hwrite) begin
            ph_d = PhWrite;
         end else begin
            ph_d   = PhRead;
            wait_d = 2'(WAIT_STATES);
         end
      end else if (ph_q == PhErr1) begin
         ph_d = PhErr2;
      end else if (hready_resp) begin
         ph_d = PhIdle;
      end
   end

   always_comb begin
      hready_resp = 1'b1;
      hresp       = 2'b00;
      unique case (ph_q)
         PhRead:  hready_resp = (wait_q == 2'd0);
         PhErr1: begin
            hready_resp = 1'b0;
            hresp       = 2'b01;
         end
         PhErr2:  hresp = 2'b01;
         default: ;
      endcase
   end

   assign ahb_io.hready_resp = hready_resp;
   assign ahb_io.hresp       = hresp;
   assign ahb_io.hrdata      = hrdata_q;

   // ---------------- array and read forwarding ----------------
   assign ahb_we  = (ph_q == PhWrite);
   assign mem_we  = bist_we | ahb_we;
   assign wr_idx  = bist_we ? idx_q : dp_idx_q;
   assign wr_be   = bist_we ? '1 : dp_be_q;
   assign wr_data = bist_we ? bist_wdata : ahb_io.hwdata;
   assign rd_idx  = bist_busy ? idx_q : ap_idx;
   assign rd_data = mem_q[rd_idx];

   // A write finishing on the read's address edge is merged lane by lane.
   always_comb begin
      fwd_data = rd_data;
      for (int unsigned i = 0; i < Lanes; i++) begin
         if (ahb_we && dp_idx_q == ap_idx && dp_be_q[i]) begin
            fwd_data[8*i +: 8] = ahb_io.hwdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge hclk_i) begin
      if (mem_we && !hreset_i) begin
         for (int unsigned i = 0; i < Lanes; i++) begin
            if (wr_be[i]) mem_q[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
         end
      end
   end

   always_ff @(posedge hclk_i) begin
      if (hreset_i) begin
         hrdata_q <= '0;
      end else if (accept && !ap_err && !ahb_io.hwrite) begin
         hrdata_q <= fwd_data;
      end
   end

   // ---------------- March C- BIST FSM ----------------
   assign bist_busy = (st_q != StIdle);
   assign start_ok  = (st_q == StIdle) && bist_start_i && (ph_q == PhIdle) && !accept;

   always_ff @(posedge hclk_i) begin
      if (hreset_i) begin
         st_q        <= StIdle;
         idx_q       <= '0;
         sub_q       <= 1'b0;
         fin_cmp_q   <= 1'b0;
         fin_idx_q   <= '0;
         done_q      <= 1'b0;
         fail_q      <= 1'b0;
         fail_addr_q <= '0;
         bist_rd_q   <= '0;
      end else begin
         st_q        <= st_d;
         idx_q       <= idx_d;
         sub_q       <= sub_d;
         fin_cmp_q   <= fin_cmp_d;
         fin_idx_q   <= fin_idx_d;
         done_q      <= done_d;
         fail_q      <= fail_d;
         fail_addr_q <= fail_addr_d;
         bist_rd_q   <= rd_data;
      end
   end

   // Up elements rely on the index wrapping from IdxLast to 0 at element end.
   always_comb begin
      st_d        = st_q;
      idx_d       = idx_q;
      sub_d       = sub_q;
      fin_cmp_d   = 1'b0;
      fin_idx_d   = idx_q;
      done_d      = done_q;
      fail_d      = fail_q;
      fail_addr_d = fail_addr_q;
      unique case (st_q)
         StIdle: begin
            if (start_ok) begin
               st_d        = StW0;
               idx_d       = '0;
               sub_d       = 1'b0;
               done_d      = 1'b0;
               fail_d      = 1'b0;
               fail_addr_d = '0;
            end
         end
         StW0: begin
            idx_d = idx_q + 1'b1;
            if (idx_q == IdxLast) st_d = StR0W1Up;
         end
         StR0W1Up, StR1W0Up: begin
            sub_d = ~sub_q;
            if (sub_q) idx_d = idx_q + 1'b1;
            if (sub_q && idx_q == IdxLast) begin
               st_d = (st_q == StR0W1Up) ? StR1W0Up : StR0W1Dn;
               if (st_q == StR1W0Up) idx_d = IdxLast;
            end
         end
         StR0W1Dn, StR1W0Dn: begin
            sub_d = ~sub_q;
            if (sub_q) idx_d = idx_q - 1'b1;
            if (sub_q && idx_q == '0) begin
               st_d = (st_q == StR0W1Dn) ? StR1W0Dn : StR0Fin;
               if (st_q == StR1W0Dn) idx_d = '0;
            end
         end
         StR0Fin: begin
            if (!sub_q) begin
               fin_cmp_d = 1'b1;
               if (idx_q == IdxLast) sub_d = 1'b1;
               else idx_d = idx_q + 1'b1;
            end else begin
               st_d   = StIdle;
               sub_d  = 1'b0;
               idx_d  = '0;
               done_d = 1'b1;
            end
         end
         default: st_d = StIdle;
      endcase
      if (miscmp && !fail_q) begin
         fail_d      = 1'b1;
         fail_addr_d = cmp_idx;
      end
   end

   always_comb begin
      bist_we    = 1'b0;
      bist_wdata = '0;
      cmp_en     = 1'b0;
      cmp_exp    = '0;
      cmp_idx    = idx_q;
      unique case (st_q)
         StW0:     bist_we = 1'b1;
         StR0W1Up, StR0W1Dn: begin
            cmp_en     = sub_q;
            bist_we    = sub_q;
            bist_wdata = '1;
         end
         StR1W0Up, StR1W0Dn: begin
            cmp_en  = sub_q;
            bist_we = sub_q;
            cmp_exp = '1;
         end
         StR0Fin: begin
            cmp_en  = fin_cmp_q;
            cmp_idx = fin_idx_q;
         end
         default: ;
      endcase
      if (bist_we && bist_inject_i && idx_q == AddrW'(3)) bist_wdata[0] = ~bist_wdata[0];
   end

   assign miscmp           = cmp_en && (bist_rd_q != cmp_exp);
   assign bist_busy_o      = bist_busy;
   assign bist_done_o      = done_q;
   assign bist_fail_o      = fail_q;
   assign bist_fail_addr_o = fail_addr_q;

endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// Directed bench: a zero-wait 16-word instance (vectors, forwarding, BIST)
// and a two-wait-state instance for the stretched read data phase.
module tb_ahb_sram_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        hreset;
   logic        hsel_a, hsel_b, hwrite;
   logic [31:0] haddr, hwdata;
   logic [2:0]  hsize;
   logic [1:0]  htrans;
   logic        bist_start, bist_inject;
   logic        busy_a, done_a, fail_a, busy_b, done_b, fail_b;
   logic [3:0]  faddr_a, faddr_b;

   int n_total = 0;
   int n_pass  = 0;

   ahb_sram_ctrl_if #(.DATA_W(32)) bus_a ();
   ahb_sram_ctrl_if #(.DATA_W(32)) bus_b ();

   assign bus_a.hsel   = hsel_a;
   assign bus_a.haddr  = haddr;
   assign bus_a.hwrite = hwrite;
   assign bus_a.hsize  = hsize;
   assign bus_a.htrans = htrans;
   assign bus_a.hwdata = hwdata;
   assign bus_a.hready = bus_a.hready_resp;
   assign bus_b.hsel   = hsel_b;
   assign bus_b.haddr  = haddr;
   assign bus_b.hwrite = hwrite;
   assign bus_b.hsize  = hsize;
   assign bus_b.htrans = htrans;
   assign bus_b.hwdata = hwdata;
   assign bus_b.hready = bus_b.hready_resp;

   ahb_sram_ctrl #(.DATA_W(32), .MEM_BYTES(64), .WAIT_STATES(0)) u_dut_a (
      .hclk_i           (clk),
      .hreset_i         (hreset),
      .ahb_io           (bus_a),
      .bist_start_i     (bist_start),
      .bist_inject_i    (bist_inject),
      .bist_busy_o      (busy_a),
      .bist_done_o      (done_a),
      .bist_fail_o      (fail_a),
      .bist_fail_addr_o (faddr_a)
   );

   ahb_sram_ctrl #(.DATA_W(32), .MEM_BYTES(64), .WAIT_STATES(2)) u_dut_b (
      .hclk_i           (clk),
      .hreset_i         (hreset),
      .ahb_io           (bus_b),
      .bist_start_i     (1'b0),
      .bist_inject_i    (1'b0),
      .bist_busy_o      (busy_b),
      .bist_done_o      (done_b),
      .bist_fail_o      (fail_b),
      .bist_fail_addr_o (faddr_b)
   );

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [2:0]  size;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic [1:0]  exp_resp;
      int          exp_cyc;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Single transfer; returns first/last-cycle hresp, final hrdata and data-phase length.
   task automatic xfer(input bit use_b, input bit wr, input logic [31:0] addr,
                       input logic [2:0] size, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic [1:0] resp0,
                       output logic [1:0] resp, output int cycles);
      logic rdy;
      hsel_a = !use_b;
      hsel_b = use_b;
      haddr  = addr;
      hwrite = wr;
      hsize  = size;
      htrans = 2'b10;
      @(posedge clk); #1;
      hsel_a = 1'b0;
      hsel_b = 1'b0;
      htrans = 2'b00;
      hwdata = wdata;
      cycles = 0;
      resp0  = 2'bxx;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         cycles++;
         rdy   = use_b ? bus_b.hready_resp : bus_a.hready_resp;
         resp  = use_b ? bus_b.hresp : bus_a.hresp;
         rdata = use_b ? bus_b.hrdata : bus_a.hrdata;
         if (c == 0) resp0 = resp;
         if (rdy) break;
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
   endtask

   task automatic bist_pulse();
      bist_start = 1'b1;
      @(posedge clk); #1;
      bist_start = 1'b0;
   endtask

   task automatic count_busy(output int cnt);
      cnt = 0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (busy_a) cnt++;
         else break;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd, rd2;
      logic [1:0]  rs0, rs, rs0b, rsb;
      int          cy, cyb, cnt;

      hreset = 1'b1; hsel_a = 1'b0; hsel_b = 1'b0; haddr = '0; hwrite = 1'b0;
      hsize = '0; htrans = '0; hwdata = '0; bist_start = 1'b0; bist_inject = 1'b0;

      vecs.push_back(vec_t'{1'b1, 32'h00, 3'd2, 32'h01234567, 32'h0, 2'b00, 1});
      vecs.push_back(vec_t'{1'b1, 32'h10, 3'd2, 32'h11223344, 32'h0, 2'b00, 1});
      vecs.push_back(vec_t'{1'b1, 32'h11, 3'd0, 32'h0000AA00, 32'h0, 2'b00, 1});
      vecs.push_back(vec_t'{1'b0, 32'h10, 3'd2, 32'h0, 32'h1122AA44, 2'b00, 1});
      vecs.push_back(vec_t'{1'b0, 32'h12, 3'd1, 32'h0, 32'h1122AA44, 2'b00, 1});
      vecs.push_back(vec_t'{1'b1, 32'h20, 3'd2, 32'hCAFEF00D, 32'h0, 2'b00, 1});
      vecs.push_back(vec_t'{1'b1, 32'h22, 3'd1, 32'h5A5A0000, 32'h0, 2'b00, 1});
      vecs.push_back(vec_t'{1'b1, 32'h23, 3'd0, 32'h77000000, 32'h0, 2'b00, 1});
      vecs.push_back(vec_t'{1'b0, 32'h20, 3'd2, 32'h0, 32'h775AF00D, 2'b00, 1});
      vecs.push_back(vec_t'{1'b0, 32'h40, 3'd2, 32'h0, 32'h0, 2'b01, 2});
      vecs.push_back(vec_t'{1'b1, 32'h01, 3'd1, 32'hFFFF0000, 32'h0, 2'b01, 2});
      vecs.push_back(vec_t'{1'b1, 32'h04, 3'd3, 32'hFFFFFFFF, 32'h0, 2'b01, 2});
      vecs.push_back(vec_t'{1'b0, 32'h3E, 3'd2, 32'h0, 32'h0, 2'b01, 2});
      vecs.push_back(vec_t'{1'b0, 32'h00, 3'd2, 32'h0, 32'h01234567, 2'b00, 1});
      vecs.push_back(vec_t'{1'b1, 32'h3C, 3'd2, 32'h89ABCDEF, 32'h0, 2'b00, 1});
      vecs.push_back(vec_t'{1'b0, 32'h3C, 3'd2, 32'h0, 32'h89ABCDEF, 2'b00, 1});
      vecs.push_back(vec_t'{1'b0, 32'h21, 3'd0, 32'h0, 32'h775AF00D, 2'b00, 1});

      repeat (3) @(posedge clk);
      #1 hreset = 1'b0;
      @(negedge clk);
      check("rst a hrdata", 64'(bus_a.hrdata), 64'h0);
      check("rst a hready_resp", 64'(bus_a.hready_resp), 64'h1);
      check("rst a hresp", 64'(bus_a.hresp), 64'h0);
      check("rst a bist", 64'({busy_a, done_a, fail_a, faddr_a}), 64'h0);
      check("rst b hrdata", 64'(bus_b.hrdata), 64'h0);
      check("rst b ready/bist", 64'({bus_b.hready_resp, busy_b, done_b, fail_b, faddr_b}),
            64'h80);
      @(posedge clk); #1;

      for (int i = 0; i < vecs.size(); i++) begin
         xfer(1'b0, vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].wdata, rd, rs0, rs, cy);
         check($sformatf("vec%0d resp first", i), 64'(rs0), 64'(vecs[i].exp_resp));
         check($sformatf("vec%0d resp last", i), 64'(rs), 64'(vecs[i].exp_resp));
         check($sformatf("vec%0d cycles", i), 64'(cy), 64'(vecs[i].exp_cyc));
         if (!vecs[i].wr && vecs[i].exp_resp == 2'b00)
            check($sformatf("vec%0d hrdata", i), 64'(rd), 64'(vecs[i].exp_rdata));
      end

      // Back-to-back write then read of the same word: full and single-byte forwarding.
      hsel_a = 1'b1; haddr = 32'h10; hwrite = 1'b1; hsize = 3'd2; htrans = 2'b10;
      @(posedge clk); #1;
      hwdata = 32'hDEADBEEF; hwrite = 1'b0;
      @(posedge clk); #1;
      haddr = 32'h13; hwrite = 1'b1; hsize = 3'd0;
      @(negedge clk);
      check("fwd word hrdata", 64'(bus_a.hrdata), 64'hDEADBEEF);
      check("fwd word ready/resp", 64'({bus_a.hready_resp, bus_a.hresp}), 64'h4);
      @(posedge clk); #1;
      hwdata = 32'h99000000; haddr = 32'h10; hwrite = 1'b0; hsize = 3'd2;
      @(posedge clk); #1;
      hsel_a = 1'b0; htrans = 2'b00;
      @(negedge clk);
      check("fwd byte hrdata", 64'(bus_a.hrdata), 64'h99ADBEEF);
      @(posedge clk); #1;
      xfer(1'b0, 1'b0, 32'h10, 3'd2, 32'h0, rd, rs0, rs, cy);
      check("after fwd array", 64'(rd), 64'h99ADBEEF);

      // Two wait states; second address phase held on the bus must wait its turn.
      xfer(1'b1, 1'b1, 32'h08, 3'd2, 32'h0BADF00D, rd, rs0, rs, cy);
      check("ws write cycles", 64'(cy), 64'd1);
      xfer(1'b1, 1'b1, 32'h0C, 3'd2, 32'h12345678, rd, rs0, rs, cy);
      hsel_b = 1'b1; haddr = 32'h08; hwrite = 1'b0; hsize = 3'd2; htrans = 2'b10;
      @(posedge clk); #1;
      haddr = 32'h0C;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("ws rd1 ready c%0d", k), 64'(bus_b.hready_resp), 64'(k == 2));
         if (k == 2) check("ws rd1 hrdata", 64'(bus_b.hrdata), 64'h0BADF00D);
         @(posedge clk); #1;
      end
      hsel_b = 1'b0; htrans = 2'b00;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("ws rd2 ready c%0d", k), 64'(bus_b.hready_resp), 64'(k == 2));
         if (k == 2) check("ws rd2 hrdata", 64'(bus_b.hrdata), 64'h12345678);
         @(posedge clk); #1;
      end

      // Clean BIST run with an AHB read attempted while it owns the array.
      bist_pulse();
      fork
         count_busy(cnt);
         begin
            repeat (20) @(posedge clk);
            #1;
            xfer(1'b0, 1'b0, 32'h10, 3'd2, 32'h0, rd2, rs0b, rsb, cyb);
         end
      join
      check("bist busy cycles", 64'(cnt), 64'd161);
      check("bist done/fail", 64'({done_a, fail_a}), 64'h2);
      check("ahb during bist resp", 64'({rs0b, rsb}), 64'h5);
      check("ahb during bist cycles", 64'(cyb), 64'd2);
      @(posedge clk); #1;
      xfer(1'b0, 1'b0, 32'h10, 3'd2, 32'h0, rd, rs0, rs, cy);
      check("post bist word4", 64'(rd), 64'h0);
      xfer(1'b0, 1'b0, 32'h3C, 3'd2, 32'h0, rd, rs0, rs, cy);
      check("post bist word15", 64'(rd), 64'h0);

      // Fault injected on word 3.
      bist_inject = 1'b1;
      bist_pulse();
      count_busy(cnt);
      check("inject busy cycles", 64'(cnt), 64'd161);
      check("inject done/fail", 64'({done_a, fail_a}), 64'h3);
      check("inject fail_addr", 64'(faddr_a), 64'h3);
      @(posedge clk); #1;

      // Reset in the middle of a failing run.
      bist_pulse();
      repeat (60) @(posedge clk);
      @(negedge clk);
      check("midrun busy/done/fail", 64'({busy_a, done_a, fail_a}), 64'h5);
      @(posedge clk); #1;
      hreset = 1'b1;
      @(posedge clk); #1;
      hreset = 1'b0;
      bist_inject = 1'b0;
      @(negedge clk);
      check("reset bist outputs", 64'({busy_a, done_a, fail_a, faddr_a}), 64'h0);
      check("reset ready/resp", 64'({bus_a.hready_resp, bus_a.hresp}), 64'h4);
      @(posedge clk); #1;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
